// File: rtl/usb3_ep0_in_sched.sv
// EP0 control-IN data-stage scheduler: splits the EP0 response into max-packet
// packets, handles retry/ZLP and arms EP0 when done. Optional: USB3_EP0_SCHED_STATS_EN.
module usb3_ep0_in_sched #(
  parameter int MAXPKT_BYTES = 512,
  parameter int ARM_TIMEOUT  = 255
) (
  input  logic        local_clk,
  input  logic        reset,
  input  logic        ep_hasdata,
  input  logic [10:0] ep_len,
  input  logic [15:0] req_wlen,
  output logic        ep_arm,
  input  logic        ep_arm_ack,
  output logic [8:0]  ep_addr,
  input  logic [8:0]  prot_addr,
  output logic        pkt_valid,
  output logic [10:0] pkt_len,
  output logic        pkt_last,
  input  logic        pkt_take,
  input  logic        pkt_ack,
  input  logic        pkt_retry,
  output logic        busy,
  output logic        err_arm_timeout,
`ifdef USB3_EP0_SCHED_STATS_EN
  output logic [15:0] stat_pkts,
  output logic [15:0] stat_retries,
`endif
  output logic [2:0]  dbg_state
);

  localparam int                LOG2_MAX = $clog2(MAXPKT_BYTES);
  localparam logic [10:0]       MAX_L    = 11'(MAXPKT_BYTES);
  localparam int                CNT_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_OFFER, S_INFLIGHT, S_ARM, S_WAIT_REL} state_t;

  state_t           state, state_d;
  logic             hasdata_q;
  logic [10:0]      remain;
  logic [8:0]       pkt_word_base;
  logic             zlp_need;
  logic [CNT_W-1:0] arm_cnt;
  logic             err_q;

  logic        start, zlp_new, do_ack, do_retry, arm_to, cur_last;
  logic [10:0] wlen_sat, total, cur_len;

  // Handshake: a packet is offered while pkt_valid; pkt_take accepts it, after
  // which exactly one of pkt_ack/pkt_retry (retry wins if both) closes it.
  assign start    = ep_hasdata && !hasdata_q;
  assign wlen_sat = (req_wlen > 16'd2047) ? 11'd2047 : req_wlen[10:0];
  assign total    = (ep_len < wlen_sat) ? ep_len : wlen_sat;
  assign zlp_new  = (total != 11'd0) && (total[LOG2_MAX-1:0] == '0) &&
                    (req_wlen > {5'd0, total});
  assign cur_len  = (remain > MAX_L) ? MAX_L : remain;
  // A pending ZLP keeps the final full packet from being marked last.
  assign cur_last = (remain <= MAX_L) && !zlp_need;
  assign do_retry = (state == S_INFLIGHT) && pkt_retry;
  assign do_ack   = (state == S_INFLIGHT) && pkt_ack && !pkt_retry;
  assign arm_to   = (state == S_ARM) && !ep_arm_ack && (arm_cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (start) state_d = S_OFFER;
      S_OFFER:    if (pkt_take) state_d = S_INFLIGHT;
      S_INFLIGHT: begin
        if (do_retry)    state_d = S_OFFER;
        else if (do_ack) state_d = cur_last ? S_ARM : S_OFFER;
      end
      S_ARM: begin
        if (ep_arm_ack)  state_d = S_WAIT_REL;
        else if (arm_to) state_d = S_IDLE;
      end
      S_WAIT_REL: if (!ep_hasdata) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_valid = (state == S_OFFER);
    pkt_len   = 11'd0;
    pkt_last  = 1'b0;
    if ((state == S_OFFER) || (state == S_INFLIGHT)) begin
      pkt_len  = cur_len;
      pkt_last = cur_last;
    end
    ep_arm          = (state == S_ARM);
    busy            = (state != S_IDLE);
    err_arm_timeout = err_q;
    ep_addr         = prot_addr + pkt_word_base;
    dbg_state       = state;
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      state         <= S_IDLE;
      // Sampling the live level means hasdata held across reset is not an edge.
      hasdata_q     <= ep_hasdata;
      remain        <= 11'd0;
      pkt_word_base <= 9'd0;
      zlp_need      <= 1'b0;
      arm_cnt       <= '0;
      err_q         <= 1'b0;
    end else begin
      state     <= state_d;
      hasdata_q <= ep_hasdata;
      if ((state == S_IDLE) && start) begin
        remain        <= total;
        pkt_word_base <= 9'd0;
        zlp_need      <= zlp_new;
      end
      if (do_ack) begin
        remain        <= remain - cur_len;
        pkt_word_base <= pkt_word_base + cur_len[10:2];
        if (remain == cur_len) zlp_need <= 1'b0;
      end
      arm_cnt <= (state == S_ARM) ? arm_cnt + 1'b1 : '0;
      if (arm_to) err_q <= 1'b1;
    end
  end

`ifdef USB3_EP0_SCHED_STATS_EN
  always_ff @(posedge local_clk) begin
    if (reset) begin
      stat_pkts    <= 16'd0;
      stat_retries <= 16'd0;
    end else begin
      if (do_ack && (stat_pkts != 16'hFFFF))      stat_pkts    <= stat_pkts + 16'd1;
      if (do_retry && (stat_retries != 16'hFFFF)) stat_retries <= stat_retries + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb3_ep0_in_sched.sv
// Scoreboard bench for usb3_ep0_in_sched: a transfer-level packet model feeds an
// expected queue that a take-monitor drains; arm, timeout and reset are checked directly.
module tb_usb3_ep0_in_sched;

  localparam int MAXPKT = 512;

  logic        local_clk = 1'b0;
  logic        reset, ep_hasdata, ep_arm, ep_arm_ack;
  logic [10:0] ep_len, pkt_len;
  logic [15:0] req_wlen;
  logic [8:0]  ep_addr, prot_addr;
  logic        pkt_valid, pkt_last, pkt_take, pkt_ack, pkt_retry, busy, err_arm_timeout;
  logic [2:0]  dbg_state;
`ifdef USB3_EP0_SCHED_STATS_EN
  logic [15:0] stat_pkts, stat_retries;
`endif

  usb3_ep0_in_sched dut (
    .local_clk(local_clk), .reset(reset), .ep_hasdata(ep_hasdata), .ep_len(ep_len),
    .req_wlen(req_wlen), .ep_arm(ep_arm), .ep_arm_ack(ep_arm_ack), .ep_addr(ep_addr),
    .prot_addr(prot_addr), .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_last(pkt_last),
    .pkt_take(pkt_take), .pkt_ack(pkt_ack), .pkt_retry(pkt_retry), .busy(busy),
    .err_arm_timeout(err_arm_timeout),
`ifdef USB3_EP0_SCHED_STATS_EN
    .stat_pkts(stat_pkts), .stat_retries(stat_retries),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 local_clk = ~local_clk;

  logic [11:0] exp_q[$];   // {last, len}
  int n_checks = 0;
  int n_fail = 0;
  int exp_pkts = 0;
  int exp_retries = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge local_clk);
    #1;
  endtask

  task automatic smp;
    @(negedge local_clk);
  endtask

  // monitor: every accepted offer is compared against the next expected packet
  always @(negedge local_clk) begin
    logic [11:0] e;
    if (!reset && pkt_valid && pkt_take) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pkt_len", 32'(pkt_len), 32'(e[10:0]));
        check("pkt_last", 32'(pkt_last), 32'(e[11]));
      end
    end
  end

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    smp;
    while (!pkt_valid && k < 50) begin
      smp;
      k++;
    end
    check(name, 32'(pkt_valid), 32'd1);
  endtask

  // driver: one full control-IN data stage
  task automatic do_xfer(input int len, input int wlen, input logic [3:0] retry_mask,
                         input bit both, input bit arm_ack_mode);
    logic [11:0] pk[$];
    logic [11:0] item;
    int bases[$];
    int wsat, tot, rem, b, l, i, c;
    bit zlp, retried, was_retry;

    wsat = (wlen > 2047) ? 2047 : wlen;
    tot  = (len < wsat) ? len : wsat;
    zlp  = (tot != 0) && (tot % MAXPKT == 0) && (wlen > tot);
    rem  = tot;
    b    = 0;
    do begin
      l    = (rem > MAXPKT) ? MAXPKT : rem;
      rem -= l;
      item = {((rem == 0) && !zlp), 11'(l)};
      pk.push_back(item);
      bases.push_back(b);
      b = (b + l / 4) % 512;
    end while (rem > 0);
    if (zlp) begin
      pk.push_back({1'b1, 11'd0});
      bases.push_back(b);
    end
    foreach (pk[j]) exp_q.push_back(pk[j]);

    ep_hasdata = 1'b0;
    tick;
    tick;
    ep_len     = 11'(len);
    req_wlen   = 16'(wlen);
    ep_hasdata = 1'b1;
    tick;

    i = 0;
    retried = 1'b0;
    while (i < pk.size()) begin
      wait_valid("offer_seen");
      tick;
      pkt_take = 1'b1;
      tick;
      pkt_take  = 1'b0;
      prot_addr = (i == 1) ? 9'd3 : 9'($urandom_range(0, 511));
      #1;
      item = pk[i];
      check("ep_addr", 32'(ep_addr), 32'((bases[i] + int'(prot_addr)) % 512));
      check("valid_drop", 32'(pkt_valid), 32'd0);
      check("inflight_len", 32'(pkt_len), 32'(item[10:0]));
      repeat ($urandom_range(0, 2)) tick;
      was_retry = retry_mask[i % 4] && !retried;
      if (was_retry) begin
        pkt_retry = 1'b1;
        pkt_ack   = both;
        exp_q.push_front(pk[i]);
        retried = 1'b1;
        exp_retries++;
      end else begin
        pkt_ack = 1'b1;
        exp_pkts++;
      end
      tick;
      pkt_retry = 1'b0;
      pkt_ack   = 1'b0;
      if (!was_retry) begin
        if (i < pk.size() - 1) begin
          smp;
          check("ack_to_valid", 32'(pkt_valid), 32'd1);
        end
        i++;
      end
    end

    smp;
    check("ep_arm_rise", 32'(ep_arm), 32'd1);
    if (arm_ack_mode) begin
      repeat ($urandom_range(1, 10)) begin
        smp;
        check("arm_hold", 32'(ep_arm), 32'd1);
      end
      tick;
      ep_arm_ack = 1'b1;
      tick;
      smp;
      check("arm_drop", 32'(ep_arm), 32'd0);
      check("busy_wait_rel", 32'(busy), 32'd1);
      tick;
      ep_arm_ack = 1'b0;
      tick;
      smp;
      check("hold_wait_rel", 32'(busy), 32'd1);
      tick;
      ep_hasdata = 1'b0;
      tick;
      smp;
      check("idle_after_rel", 32'(busy), 32'd0);
    end else begin
      c = 0;
      while (ep_arm === 1'b1 && c < 400) begin
        c++;
        smp;
      end
      check("arm_timeout_cycles", 32'(c), 32'd255);
      check("err_arm_timeout", 32'(err_arm_timeout), 32'd1);
      check("arm_after_timeout", 32'(ep_arm), 32'd0);
      check("idle_after_timeout", 32'(busy), 32'd0);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 32'(pkt_valid), 32'd0);
    check({name, "_len"}, 32'(pkt_len), 32'd0);
    check({name, "_last"}, 32'(pkt_last), 32'd0);
    check({name, "_arm"}, 32'(ep_arm), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_err"}, 32'(err_arm_timeout), 32'd0);
    check({name, "_addr"}, 32'(ep_addr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, wlen, r;
    reset = 1'b1; ep_hasdata = 1'b0; ep_len = '0; req_wlen = '0; ep_arm_ack = 1'b0;
    prot_addr = '0; pkt_take = 1'b0; pkt_ack = 1'b0; pkt_retry = 1'b0;
    repeat (3) tick;
    smp;
    check_all_zero("reset");
    tick;
    reset = 1'b0;

    do_xfer(18, 64, 4'b0000, 1'b0, 1'b1);
    do_xfer(1100, 2000, 4'b0000, 1'b0, 1'b1);
    do_xfer(1024, 1100, 4'b0000, 1'b0, 1'b1);
    do_xfer(1024, 1024, 4'b0000, 1'b0, 1'b1);
    do_xfer(1100, 2000, 4'b0010, 1'b0, 1'b1);
    do_xfer(1100, 2000, 4'b0010, 1'b1, 1'b1);
    do_xfer(0, 0, 4'b0000, 1'b0, 1'b1);
    do_xfer(600, 40000, 4'b0000, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 2047);
      r   = $urandom_range(0, 3);
      case (r)
        0:       wlen = len;
        1:       wlen = $urandom_range(0, 65535);
        2:       begin len = 512 * $urandom_range(0, 3); wlen = len + $urandom_range(0, 100); end
        default: wlen = len + $urandom_range(1, 100);
      endcase
      do_xfer(len, wlen, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    end
`ifdef USB3_EP0_SCHED_STATS_EN
    check("stat_pkts", 32'(stat_pkts), 32'(exp_pkts));
    check("stat_retries", 32'(stat_retries), 32'(exp_retries));
`endif
    do_xfer(18, 64, 4'b0000, 1'b0, 1'b0);

    // reset in INFLIGHT with hasdata held high
    ep_hasdata = 1'b0;
    tick;
    tick;
    ep_len = 11'd1100; req_wlen = 16'd2000; ep_hasdata = 1'b1;
    exp_q.push_back({1'b0, 11'd512});
    tick;
    wait_valid("offer_before_reset");
    tick;
    pkt_take = 1'b1;
    tick;
    pkt_take = 1'b0;
    reset = 1'b1;
    prot_addr = 9'd0;
    tick;
    smp;
    check_all_zero("mid_reset");
    tick;
    reset = 1'b0;
    repeat (5) begin
      smp;
      check("stale_hasdata_busy", 32'(busy), 32'd0);
      check("stale_hasdata_valid", 32'(pkt_valid), 32'd0);
    end
    check("reset_q_drained", 32'(exp_q.size()), 32'd0);
    do_xfer(18, 64, 4'b0000, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
